branch_pc_ctrl: RTL and testbench

Program-counter and branch-resolution stage of the 16-bit custom RISC core. It sits directly downstream of the equality comparator and consumes that 1-bit equal flag. It resolves BEQ, BNE and JMP, redirects the PC, and drives a fixed-length flush of the fetch/decode pipeline on a taken branch. Between branches it advances the PC by one word per cycle unless stalled.

---
 rtl/branch_pc_ctrl_pkg.sv | 36 +++
 rtl/branch_pc_ctrl_flush_timer.sv | 29 ++
 rtl/branch_pc_ctrl.sv | 119 +++++++++++
 tb/tb_branch_pc_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/branch_pc_ctrl_pkg.sv
// Shared encodings and helpers for the PC / branch-resolution stage.
// Imported by branch_pc_ctrl and its flush timer.
package branch_pc_ctrl_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JMP  = 2'b11
    } br_type_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic br_taken(input logic [1:0] t, input logic eq);
        logic r;
        r = 1'b0;
        unique case (br_type_e'(t))
            BR_BEQ:  r = eq;
            BR_BNE:  r = ~eq;
            BR_JMP:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_pc_ctrl_flush_timer.sv
// Loadable down-counter for the post-branch bubble window.
// o_done is high while the count is 1, i.e. the last bubble cycle.
module flush_timer
    import branch_pc_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = cnt_w(FLUSH_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(FLUSH_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/branch_pc_ctrl.sv
// PC generation and BEQ/BNE/JMP resolution with a fixed-length
// fetch/decode flush after every taken branch.
module branch_pc_ctrl
    import branch_pc_ctrl_pkg::*;
#(
    parameter int              PC_W         = 16,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            br_valid,
    input  logic [1:0]      br_type,
    input  logic            br_eq,
    input  logic [PC_W-1:0] br_target,
    output logic            br_ready,
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic            flush,
    output logic            taken
);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic            r_pc_valid;
    logic            w_pc_valid_nxt;
    logic            r_flush;
    logic            w_flush_nxt;
    logic            r_taken;
    logic            w_taken_nxt;
    logic            w_load;
    logic            w_done;
    logic            w_take;

    flush_timer #(
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_flush_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .o_done (w_done)
    );

    assign w_take = br_valid & br_taken(br_type, br_eq);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pc_valid_nxt = r_pc_valid;
        w_flush_nxt    = r_flush;
        w_taken_nxt    = 1'b0;
        w_load         = 1'b0;
        unique case (r_state)
            ST_BOOT: begin
                w_state_nxt    = ST_RUN;
                w_pc_valid_nxt = 1'b1;
            end
            ST_RUN: begin
                // a taken branch wins over a stall in the same cycle
                if (w_take) begin
                    w_state_nxt    = ST_FLUSH;
                    w_pc_nxt       = br_target;
                    w_pc_valid_nxt = 1'b0;
                    w_flush_nxt    = 1'b1;
                    w_taken_nxt    = 1'b1;
                    w_load         = 1'b1;
                end else begin
                    w_pc_valid_nxt = 1'b1;
                    w_flush_nxt    = 1'b0;
                    if (!stall) begin
                        w_pc_nxt = r_pc + PC_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (w_done) begin
                    w_state_nxt    = ST_RUN;
                    w_pc_valid_nxt = 1'b1;
                    w_flush_nxt    = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_flush    <= 1'b0;
            r_taken    <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_pc_valid <= w_pc_valid_nxt;
            r_flush    <= w_flush_nxt;
            r_taken    <= w_taken_nxt;
        end
    end

    assign br_ready = (r_state == ST_RUN);
    assign pc       = r_pc;
    assign pc_valid = r_pc_valid;
    assign flush    = r_flush;
    assign taken    = r_taken;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Directed-vector bench for branch_pc_ctrl (default parameters).
// Samples outputs 1ns after each rising edge.
module tb_branch_pc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_valid;
    logic [1:0]  br_type;
    logic        br_eq;
    logic [15:0] br_target;
    logic        br_ready;
    logic [15:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        taken;

    int n_vec;
    int n_err;

    branch_pc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_type   (br_type),
        .br_eq     (br_eq),
        .br_target (br_target),
        .br_ready  (br_ready),
        .pc        (pc),
        .pc_valid  (pc_valid),
        .flush     (flush),
        .taken     (taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pc, pc_valid, flush, taken, br_ready in one call
    task automatic chk_all(input string tag, input logic [15:0] e_pc,
                           input logic e_v, input logic e_f,
                           input logic e_t, input logic e_r);
        chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
        chk({tag, ".pc_valid"}, 32'(pc_valid), 32'(e_v));
        chk({tag, ".flush"}, 32'(flush), 32'(e_f));
        chk({tag, ".taken"}, 32'(taken), 32'(e_t));
        chk({tag, ".br_ready"}, 32'(br_ready), 32'(e_r));
    endtask

    task automatic run_to(input logic [15:0] t);
        int n;
        n = 0;
        while (pc !== t && n < 300) begin
            tick();
            n++;
        end
        chk("run_to", 32'(pc), 32'(t));
    endtask

    task automatic branch(input logic [1:0] ty, input logic eq,
                          input logic [15:0] tg);
        br_valid  = 1'b1;
        br_type   = ty;
        br_eq     = eq;
        br_target = tg;
        tick();
        br_valid  = 1'b0;
        br_type   = 2'b00;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        stall     = 1'b0;
        br_valid  = 1'b0;
        br_type   = 2'b00;
        br_eq     = 1'b0;
        br_target = 16'h0000;

        // 1: reset, boot, sequential fetch
        tick();
        tick();
        chk_all("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk_all("boot", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("run0", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("seq1", 32'(pc), 32'h0001);
        tick();
        chk("seq2", 32'(pc), 32'h0002);
        tick();
        chk("seq3", 32'(pc), 32'h0003);

        // 3a: not-taken forms
        run_to(16'h000D);
        branch(2'b00, 1'b1, 16'h0700);
        chk_all("none", 16'h000E, 1'b1, 1'b0, 1'b0, 1'b1);
        branch(2'b01, 1'b0, 16'h0700);
        chk_all("beq_nt", 16'h000F, 1'b1, 1'b0, 1'b0, 1'b1);
        branch(2'b10, 1'b1, 16'h0700);
        chk_all("bne_nt", 16'h0010, 1'b1, 1'b0, 1'b0, 1'b1);

        // 2: BEQ taken at 0010
        branch(2'b01, 1'b1, 16'h0040);
        chk_all("beq_t0", 16'h0040, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("beq_t1", 16'h0040, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("beq_t2", 16'h0040, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("beq_t3", 16'h0041, 1'b1, 1'b0, 1'b0, 1'b1);

        // 3b: BNE taken
        branch(2'b10, 1'b0, 16'h0100);
        chk_all("bne_t0", 16'h0100, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        chk_all("bne_t2", 16'h0100, 1'b1, 1'b0, 1'b0, 1'b1);

        // 4: stall holds, JMP overrides stall
        stall = 1'b1;
        tick();
        chk("stall1", 32'(pc), 32'h0100);
        tick();
        tick();
        chk("stall3", 32'(pc), 32'h0100);
        branch(2'b11, 1'b0, 16'h0080);
        chk_all("jmp_st", 16'h0080, 1'b0, 1'b1, 1'b1, 1'b0);

        // 5: branch during FLUSH is ignored, stall ignored too
        br_valid  = 1'b1;
        br_type   = 2'b11;
        br_target = 16'h0200;
        chk("fl_rdy", 32'(br_ready), 32'h0);
        tick();
        chk_all("fl_ign", 16'h0080, 1'b0, 1'b1, 1'b0, 1'b0);
        br_valid = 1'b0;
        br_type  = 2'b00;
        tick();
        chk_all("fl_end", 16'h0080, 1'b1, 1'b0, 1'b0, 1'b1);
        stall = 1'b0;
        tick();
        chk("post_fl", 32'(pc), 32'h0081);

        // 5b: wrap FFFF -> 0000
        branch(2'b11, 1'b0, 16'hFFFE);
        tick();
        tick();
        chk_all("wr_land", 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("wr_ffff", 32'(pc), 32'hFFFF);
        tick();
        chk("wr_0000", 32'(pc), 32'h0000);

        // 6: async reset in second FLUSH cycle
        branch(2'b11, 1'b0, 16'h0300);
        tick();
        chk_all("fl2", 16'h0300, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("arst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("arst_h", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_all("reboot", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("reseq1", 32'(pc), 32'h0001);
        tick();
        chk("reseq2", 32'(pc), 32'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
